// File: rtl/uart_arb_pkg.sv
// Shared state encoding, default limits and a saturating counter helper
// for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  localparam logic [15:0] DEF_TIMEOUT   = 16'd50000;
  localparam logic [15:0] DEF_MAX_BURST = 16'd16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
// Zero latency; valid low when no request is pending.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  int            cand;
  logic [IW-1:0] cidx;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    cidx  = '0;
    // Scan farthest-first so the hit nearest to ptr is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % N;
      cidx = IW'(cand);
      if (req[cidx]) begin
        valid = 1'b1;
        index = cidx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter, with per-requester packet lock.
// Start/ack one cycle after selection; grant held until i_tx_done or timeout.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT,
  parameter logic [15:0] MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_lock,
  input  logic [8*N_REQ-1:0]       i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_done,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   burst_q, burst_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          arb_vld;
  logic [IW-1:0] arb_idx;
  logic [7:0]    req_byte [N_REQ];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
    return (int'(g) == N_REQ - 1) ? '0 : g + IW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_byte[k] = i_data[8*k +: 8];
    end
  end

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr_q),
    .valid (arb_vld),
    .index (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    burst_d    = burst_q;
    tmo_d      = tmo_q;
    o_tx_start = 1'b0;
    o_ack      = '0;
    o_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          data_d  = req_byte[arb_idx];
          burst_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_tx_start = 1'b1;
        o_ack      = N_REQ'(1) << grant_q;
        burst_d    = sat_inc16(burst_q);
        tmo_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Done is checked first so it beats a timeout landing in the same cycle.
        if (i_tx_done) begin
          if (i_lock[grant_q] && i_req[grant_q] && (burst_q < MAX_BURST)) begin
            data_d  = req_byte[grant_q];
            state_d = ISSUE;
          end else begin
            ptr_d   = next_idx(grant_q);
            state_d = IDLE;
          end
        end else if (tmo_q >= TIMEOUT - 16'd1) begin
          o_err   = 1'b1;
          ptr_d   = next_idx(grant_q);
          state_d = IDLE;
        end else begin
          tmo_d = sat_inc16(tmo_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= 8'h00;
      burst_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_tx_data  = data_q;
  assign o_grant_id = grant_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed scenarios plus randomized byte transactions for uart_tx_arb,
// checked against a transaction-level model of grants, data and timeouts.
module tb_uart_tx_arb;

  localparam int N    = 4;
  localparam int TMO  = 20;
  localparam int MAXB = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   i_req;
  logic [N-1:0]   i_lock;
  logic [8*N-1:0] i_data;
  logic           i_tx_done;
  logic [N-1:0]   o_ack;
  logic           o_tx_start;
  logic [7:0]     o_tx_data;
  logic [1:0]     o_grant_id;
  logic           o_busy;
  logic           o_err;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_ptr;
  int          g;
  int          burst;
  int          j;
  bit          fin;
  bit          seen;
  logic [3:0]  rq;
  logic [3:0]  lk;
  logic [31:0] dat;
  logic [7:0]  d;
  int          order [5] = '{0, 1, 2, 3, 0};
  logic [7:0]  lb    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_REQ     (N),
    .TIMEOUT   (16'(TMO)),
    .MAX_BURST (16'(MAXB))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_lock     (i_lock),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [31:0] dv,
                      input logic done);
    @(negedge clk);
    i_req     = r;
    i_lock    = l;
    i_data    = dv;
    i_tx_done = done;
    #1;
    check_eq("ack_onehot0", 32'($onehot0(o_ack)), 32'd1);
  endtask

  task automatic expect_issue(input string tag, input int gi, input logic [7:0] dv);
    check_eq({tag, "_start"}, 32'(o_tx_start), 32'd1);
    check_eq({tag, "_ack"},   32'(o_ack),      32'd1 << gi);
    check_eq({tag, "_data"},  32'(o_tx_data),  32'(dv));
    check_eq({tag, "_gid"},   32'(o_grant_id), 32'(gi));
    check_eq({tag, "_busy"},  32'(o_busy),     32'd1);
    check_eq({tag, "_err"},   32'(o_err),      32'd0);
  endtask

  task automatic expect_wait(input string tag, input logic [7:0] dv, input logic err);
    check_eq({tag, "_start"}, 32'(o_tx_start), 32'd0);
    check_eq({tag, "_ack"},   32'(o_ack),      32'd0);
    check_eq({tag, "_data"},  32'(o_tx_data),  32'(dv));
    check_eq({tag, "_busy"},  32'(o_busy),     32'd1);
    check_eq({tag, "_err"},   32'(o_err),      32'(err));
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_busy"},  32'(o_busy),     32'd0);
    check_eq({tag, "_start"}, 32'(o_tx_start), 32'd0);
    check_eq({tag, "_ack"},   32'(o_ack),      32'd0);
    check_eq({tag, "_err"},   32'(o_err),      32'd0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    expect_idle(tag);
    check_eq({tag, "_data"}, 32'(o_tx_data),  32'd0);
    check_eq({tag, "_gid"},  32'(o_grant_id), 32'd0);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] dv, input int k);
    return dv[8*k +: 8];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; i_req = '0; i_lock = '0; i_data = '0; i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    expect_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // All four requesting, one byte each, ptr starts at 0.
    dat = 32'h44332211;
    step(4'hF, 4'h0, dat, 1'b0);
    expect_idle("all_sel");
    for (int b = 0; b < 5; b++) begin
      step(4'hF, 4'h0, dat, 1'b0);
      expect_issue("all_issue", order[b], byte_of(dat, order[b]));
      step(4'hF, 4'h0, dat, 1'b1);
      expect_wait("all_done", byte_of(dat, order[b]), 1'b0);
      step((b == 4) ? 4'h0 : 4'hF, 4'h0, dat, 1'b0);
      expect_idle("all_idle");
    end

    // Locked burst on requester 1 (ptr=1), capped at MAXB, then requester 0.
    dat = {16'h0000, lb[0], 8'hA0};
    step(4'b0011, 4'b0010, dat, 1'b0);
    expect_idle("lock_sel");
    for (int b = 0; b < 3; b++) begin
      step(4'b0011, 4'b0010, dat, 1'b0);
      expect_issue("lock_issue", 1, lb[b]);
      dat[15:8] = lb[b+1];
      step(4'b0011, 4'b0010, dat, 1'b1);
      expect_wait("lock_done", lb[b], 1'b0);
    end
    step(4'b0011, 4'b0010, dat, 1'b0);
    expect_idle("lock_release");
    step(4'b0000, 4'b0000, dat, 1'b0);
    expect_issue("lock_next", 0, 8'hA0);
    step(4'b0000, 4'b0000, dat, 1'b1);
    expect_wait("lock_next_done", 8'hA0, 1'b0);
    step(4'b0000, 4'b0000, dat, 1'b0);
    expect_idle("lock_end");

    // Single request from requester 2, dropped after selection.
    dat = 32'h00A50000;
    step(4'b0100, 4'b0000, dat, 1'b0);
    expect_idle("single_sel");
    step(4'b0000, 4'b0000, 32'hFFFFFFFF, 1'b0);
    expect_issue("single_issue", 2, 8'hA5);
    step(4'b0000, 4'b0000, 32'h0, 1'b1);
    expect_wait("single_done", 8'hA5, 1'b0);
    step(4'b0000, 4'b0000, 32'h0, 1'b0);
    expect_idle("single_idle");

    // Timeout with no done (ptr=3 -> grant 0); ptr then moves to 1.
    dat = 32'h000000C3;
    step(4'b0001, 4'b0000, dat, 1'b0);
    expect_idle("tmo_sel");
    step(4'b0000, 4'b0000, dat, 1'b0);
    expect_issue("tmo_issue", 0, 8'hC3);
    for (int k = 1; k <= TMO; k++) begin
      step(4'b0000, 4'b0000, dat, 1'b0);
      expect_wait("tmo_wait", 8'hC3, k == TMO);
    end
    dat = 32'h44332211;
    step(4'hF, 4'h0, dat, 1'b0);
    expect_idle("tmo_idle");
    step(4'h0, 4'h0, dat, 1'b0);
    expect_issue("tmo_ptr", 1, 8'h22);
    step(4'h0, 4'h0, dat, 1'b1);
    expect_wait("tmo_ptr_done", 8'h22, 1'b0);
    step(4'h0, 4'h0, dat, 1'b0);
    expect_idle("tmo_ptr_idle");

    // Done lands on the final timeout cycle: completion, no error (ptr=2).
    step(4'b0100, 4'b0000, dat, 1'b0);
    expect_idle("edge_sel");
    step(4'b0000, 4'b0000, dat, 1'b0);
    expect_issue("edge_issue", 2, 8'h33);
    for (int k = 1; k <= TMO; k++) begin
      step(4'b0000, 4'b0000, dat, k == TMO);
      expect_wait("edge_wait", 8'h33, 1'b0);
    end
    step(4'b0000, 4'b0000, dat, 1'b0);
    expect_idle("edge_idle");

    // Reset in WAIT (ptr=3 -> grant 3), then retry from ptr=0.
    dat = 32'h5A000000;
    step(4'b1000, 4'b0000, dat, 1'b0);
    expect_idle("rst_sel");
    step(4'b1000, 4'b0000, dat, 1'b0);
    expect_issue("rst_issue", 3, 8'h5A);
    step(4'b1000, 4'b0000, dat, 1'b0);
    expect_wait("rst_wait", 8'h5A, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    expect_reset_outputs("rst_async");
    repeat (2) begin
      step(4'b1000, 4'b0000, dat, 1'b1);
      expect_reset_outputs("rst_hold");
    end
    reset = 1'b0;
    step(4'b1000, 4'b0000, dat, 1'b0);
    expect_issue("rst_retry", 3, 8'h5A);
    step(4'b0000, 4'b0000, dat, 1'b1);
    expect_wait("rst_retry_done", 8'h5A, 1'b0);
    step(4'b0000, 4'b0000, dat, 1'b0);
    expect_idle("rst_retry_idle");
    m_ptr = 0;

    // Randomized transactions against the model.
    for (int ep = 0; ep < 80; ep++) begin
      repeat ($urandom_range(0, 2)) begin
        step(4'h0, 4'($urandom), $urandom, 1'($urandom));
        expect_idle("rnd_quiet");
      end
      rq  = 4'($urandom_range(1, 15));
      lk  = 4'($urandom);
      dat = $urandom;
      step(rq, lk, dat, 1'b0);
      expect_idle("rnd_sel");
      g     = rr_pick(rq, m_ptr);
      d     = byte_of(dat, g);
      burst = 0;
      fin   = 1'b0;
      while (!fin) begin
        rq    = 4'($urandom);
        rq[g] = ($urandom_range(0, 3) != 0);
        lk    = 4'($urandom);
        lk[g] = 1'($urandom);
        step(rq, lk, $urandom, 1'($urandom));
        burst++;
        expect_issue("rnd_issue", g, d);
        j    = ($urandom_range(0, 4) == 0) ? TMO + 1 : int'($urandom_range(1, TMO));
        seen = 1'b0;
        for (int k = 1; k <= TMO && !seen; k++) begin
          dat = $urandom;
          step(rq, lk, dat, k == j);
          expect_wait("rnd_wait", d, (k == TMO) && (j > TMO));
          if (k == j) begin
            seen = 1'b1;
            if (lk[g] && rq[g] && burst < MAXB) begin
              d = byte_of(dat, g);
            end else begin
              fin   = 1'b1;
              m_ptr = (g + 1) % N;
            end
          end else if (k == TMO) begin
            seen  = 1'b1;
            fin   = 1'b1;
            m_ptr = (g + 1) % N;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
